// File: rtl/tic_tac_toe_nxn.sv
// N x N, K-in-a-row game engine: cursor navigation, move placement, win/draw check, scores.
// Define TTT_CURSOR_WRAP_EN to make cursor moves wrap within a row or column.
module tic_tac_toe_nxn #(
  parameter int unsigned N  = 3,
  parameter int unsigned K  = 3,
  parameter int unsigned CW = $clog2(N * N)
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         restart,
  input  logic                         BtnL,
  input  logic                         BtnR,
  input  logic                         BtnU,
  input  logic                         BtnD,
  input  logic                         BtnC,
  output logic [CW-1:0]                I,
  output logic [N*N-1:0]               P1,
  output logic [N*N-1:0]               P2,
  output logic                         Player,
  output logic                         PlayerMoved,
  output logic                         P1Won,
  output logic                         P2Won,
  output logic                         Draw,
  output logic [$clog2(N*N+1)-1:0]     MoveCount,
  output logic [3:0]                   P1Score,
  output logic [3:0]                   P2Score
);

  localparam int unsigned NN  = N * N;
  localparam int unsigned MCW = $clog2(NN + 1);
  localparam int unsigned RW  = $clog2(N);

  typedef enum logic [1:0] {StPlay, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      btn_prev_q;
  logic [4:0]      btn, press;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic [CW-1:0]   cur_q, cur_d;
  logic [NN-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic            player_q, player_d;
  logic            moved_q, moved_d;
  logic            p1won_q, p1won_d, p2won_q, p2won_d, draw_q, draw_d;
  logic [MCW-1:0]  mc_q, mc_d;
  logic [3:0]      s1_q, s1_d, s2_q, s2_d;
  logic [NN-1:0]   occ;
  logic            win;

  // Zero padding lets every run start be indexed without range guards.
  function automatic logic has_run(input logic [NN-1:0] b);
    logic [3*NN-1:0] bx;
    logic            found, okr, okc, hr, hc, hd, ha;
    bx = '0;
    bx[NN-1:0] = b;
    found = 1'b0;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        okr = (c + int'(K) <= int'(N));
        okc = (r + int'(K) <= int'(N));
        hr  = okr;
        hc  = okc;
        hd  = okr & okc;
        ha  = okr & okc;
        for (int k = 0; k < int'(K); k++) begin
          hr = hr & bx[r * int'(N) + c + k];
          hc = hc & bx[(r + k) * int'(N) + c];
          hd = hd & bx[(r + k) * int'(N) + c + k];
          ha = ha & bx[(r + k) * int'(N) + c + int'(K) - 1 - k];
        end
        found = found | hr | hc | hd | ha;
      end
    end
    return found;
  endfunction

  assign btn   = {BtnC, BtnU, BtnD, BtnL, BtnR};
  assign press = btn & ~btn_prev_q;
  assign occ   = p1_q | p2_q;
  assign win   = has_run(player_q ? p2_q : p1_q);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    player_d = player_q;
    moved_d  = 1'b0;
    p1won_d  = p1won_q;
    p2won_d  = p2won_q;
    draw_d   = draw_q;
    mc_d     = mc_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    if (restart) begin
      state_d  = StPlay;
      row_d    = RW'(N - 1);
      col_d    = RW'(N - 1);
      p1_d     = '0;
      p2_d     = '0;
      player_d = 1'b0;
      p1won_d  = 1'b0;
      p2won_d  = 1'b0;
      draw_d   = 1'b0;
      mc_d     = '0;
    end else begin
      unique case (state_q)
        StPlay: begin
          // A C edge consumes the cycle even on an occupied cell.
          if (press[4]) begin
            if (!occ[cur_q]) begin
              if (player_q) p2_d[cur_q] = 1'b1;
              else          p1_d[cur_q] = 1'b1;
              moved_d = 1'b1;
              mc_d    = mc_q + 1'b1;
              state_d = StCheck;
            end
          end else if (press[3]) begin
            if (row_q != '0) row_d = row_q - 1'b1;
`ifdef TTT_CURSOR_WRAP_EN
            else             row_d = RW'(N - 1);
`endif
          end else if (press[2]) begin
            if (row_q != RW'(N - 1)) row_d = row_q + 1'b1;
`ifdef TTT_CURSOR_WRAP_EN
            else                     row_d = '0;
`endif
          end else if (press[1]) begin
            if (col_q != '0) col_d = col_q - 1'b1;
`ifdef TTT_CURSOR_WRAP_EN
            else             col_d = RW'(N - 1);
`endif
          end else if (press[0]) begin
            if (col_q != RW'(N - 1)) col_d = col_q + 1'b1;
`ifdef TTT_CURSOR_WRAP_EN
            else                     col_d = '0;
`endif
          end
        end
        StCheck: begin
          if (win) begin
            state_d = StDone;
            if (player_q) begin
              p2won_d = 1'b1;
              if (s2_q != 4'hF) s2_d = s2_q + 4'd1;
            end else begin
              p1won_d = 1'b1;
              if (s1_q != 4'hF) s1_d = s1_q + 4'd1;
            end
          end else if (mc_q == MCW'(NN)) begin
            draw_d  = 1'b1;
            state_d = StDone;
          end else begin
            player_d = ~player_q;
            state_d  = StPlay;
          end
        end
        StDone:  ;
        default: state_d = StPlay;
      endcase
    end
    cur_d = CW'(int'(row_d) * int'(N) + int'(col_d));
  end

  always_ff @(posedge Clk) begin
    btn_prev_q <= btn;
    if (reset) begin
      state_q  <= StPlay;
      row_q    <= RW'(N - 1);
      col_q    <= RW'(N - 1);
      cur_q    <= CW'(NN - 1);
      p1_q     <= '0;
      p2_q     <= '0;
      player_q <= 1'b0;
      moved_q  <= 1'b0;
      p1won_q  <= 1'b0;
      p2won_q  <= 1'b0;
      draw_q   <= 1'b0;
      mc_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cur_q    <= cur_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      player_q <= player_d;
      moved_q  <= moved_d;
      p1won_q  <= p1won_d;
      p2won_q  <= p2won_d;
      draw_q   <= draw_d;
      mc_q     <= mc_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign I           = cur_q;
  assign P1          = p1_q;
  assign P2          = p2_q;
  assign Player      = player_q;
  assign PlayerMoved = moved_q;
  assign P1Won       = p1won_q;
  assign P2Won       = p2won_q;
  assign Draw        = draw_q;
  assign MoveCount   = mc_q;
  assign P1Score     = s1_q;
  assign P2Score     = s2_q;

endmodule

// File: tb/tb_tic_tac_toe_nxn.sv
// Bench for tic_tac_toe_nxn: a 3x3 and a 4x4 (K=3) instance share the inputs; a scoreboard
// holds the expected bitmaps for every placement and is checked on each PlayerMoved pulse.
module tb_tic_tac_toe_nxn;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BU = 5'b01000;
  localparam logic [4:0] BD = 5'b00100;
  localparam logic [4:0] BL = 5'b00010;
  localparam logic [4:0] BR = 5'b00001;

  logic Clk = 1'b0;
  logic reset, restart, bl, br, bu, bd, bc;
  always #5 Clk = ~Clk;

  logic [3:0]  i3, mc3, s1_3, s2_3;
  logic [8:0]  p1_3, p2_3;
  logic        pl3, pm3, w1_3, w2_3, dr3;
  logic [3:0]  i4, s1_4, s2_4;
  logic [4:0]  mc4;
  logic [15:0] p1_4, p2_4;
  logic        pl4, pm4, w1_4, w2_4, dr4;

  tic_tac_toe_nxn dut (
    .Clk(Clk), .reset(reset), .restart(restart),
    .BtnL(bl), .BtnR(br), .BtnU(bu), .BtnD(bd), .BtnC(bc),
    .I(i3), .P1(p1_3), .P2(p2_3), .Player(pl3), .PlayerMoved(pm3),
    .P1Won(w1_3), .P2Won(w2_3), .Draw(dr3), .MoveCount(mc3),
    .P1Score(s1_3), .P2Score(s2_3)
  );

  tic_tac_toe_nxn #(.N(4), .K(3)) dut4 (
    .Clk(Clk), .reset(reset), .restart(restart),
    .BtnL(bl), .BtnR(br), .BtnU(bu), .BtnD(bd), .BtnC(bc),
    .I(i4), .P1(p1_4), .P2(p2_4), .Player(pl4), .PlayerMoved(pm4),
    .P1Won(w1_4), .P2Won(w2_4), .Draw(dr4), .MoveCount(mc4),
    .P1Score(s1_4), .P2Score(s2_4)
  );

  // Board under test: 3 selects dut, 4 selects dut4.
  int tn = 3;
  logic [24:0] a_p1, a_p2;
  logic [4:0]  a_i, a_mc;
  logic [3:0]  a_s1, a_s2;
  logic        a_pl, a_pm, a_w1, a_w2, a_dr;

  always_comb begin
    if (tn == 3) begin
      a_p1 = {16'b0, p1_3}; a_p2 = {16'b0, p2_3}; a_i = {1'b0, i3}; a_mc = {1'b0, mc3};
      a_s1 = s1_3; a_s2 = s2_3; a_pl = pl3; a_pm = pm3; a_w1 = w1_3; a_w2 = w2_3; a_dr = dr3;
    end else begin
      a_p1 = {9'b0, p1_4}; a_p2 = {9'b0, p2_4}; a_i = {1'b0, i4}; a_mc = mc4;
      a_s1 = s1_4; a_s2 = s2_4; a_pl = pl4; a_pm = pm4; a_w1 = w1_4; a_w2 = w2_4; a_dr = dr4;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [24:0] p1;
    logic [24:0] p2;
  } move_t;
  move_t sb[$];
  move_t sb_e;

  logic [24:0] m_p1, m_p2;
  logic        m_pl;
  int          m_row, m_col;

  always @(negedge Clk) begin
    if (a_pm === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_move", {31'b0, a_pm}, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        check_eq("sb_p1", {7'b0, a_p1}, {7'b0, sb_e.p1});
        check_eq("sb_p2", {7'b0, a_p2}, {7'b0, sb_e.p2});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    {bc, bu, bd, bl, br} = m;
    tick();
    {bc, bu, bd, bl, br} = 5'b0;
    tick();
  endtask

  task automatic clear_model();
    m_p1 = '0; m_p2 = '0; m_pl = 1'b0;
    m_row = tn - 1; m_col = tn - 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    clear_model();
    sb.delete();
  endtask

  task automatic do_restart();
    restart = 1'b1; tick(); restart = 1'b0;
    clear_model();
    sb.delete();
  endtask

  task automatic check_idle(input logic [3:0] s1e, input logic [3:0] s2e);
    check_eq("idle_i", {27'b0, a_i}, tn * tn - 1);
    check_eq("idle_p1", {7'b0, a_p1}, 32'd0);
    check_eq("idle_p2", {7'b0, a_p2}, 32'd0);
    check_eq("idle_flags", {28'b0, a_pl, a_w1, a_w2, a_dr}, 32'd0);
    check_eq("idle_mc", {27'b0, a_mc}, 32'd0);
    check_eq("idle_s1", {28'b0, a_s1}, {28'b0, s1e});
    check_eq("idle_s2", {28'b0, a_s2}, {28'b0, s2e});
  endtask

  task automatic goto(input int idx);
    int tr, tc;
    tr = idx / tn;
    tc = idx % tn;
    while (m_row > tr) begin press(BU); m_row--; end
    while (m_row < tr) begin press(BD); m_row++; end
    while (m_col > tc) begin press(BL); m_col--; end
    while (m_col < tc) begin press(BR); m_col++; end
  endtask

  task automatic place(input int idx, input bit fin);
    goto(idx);
    if (m_pl) m_p2[idx] = 1'b1;
    else      m_p1[idx] = 1'b1;
    sb.push_back('{m_p1, m_p2});
    press(BC);
    if (!fin) begin
      m_pl = ~m_pl;
      check_eq("player_turn", {31'b0, a_pl}, {31'b0, m_pl});
    end
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0;
    {bc, bu, bd, bl, br} = 5'b0;
    tick();
    do_reset();
    check_idle(4'd0, 4'd0);

    // Column-2 win for P1.
    place(8, 0); place(0, 0); place(5, 0); place(1, 0); place(2, 1);
    check_eq("win_p1_map", {7'b0, a_p1}, 32'h124);
    check_eq("win_p2_map", {7'b0, a_p2}, 32'h003);
    check_eq("win_flags", {29'b0, a_w1, a_w2, a_dr}, 32'b100);
    check_eq("win_score", {28'b0, a_s1}, 32'd1);
    check_eq("win_mc", {27'b0, a_mc}, 32'd5);
    check_eq("win_player", {31'b0, a_pl}, 32'd0);
    press(BU);
    check_eq("done_u", {27'b0, a_i}, 32'd2);
    press(BD);
    check_eq("done_d", {27'b0, a_i}, 32'd2);

    do_restart();
    check_idle(4'd1, 4'd0);

    place(0, 0); place(1, 0); place(2, 0); place(4, 0); place(3, 0);
    place(5, 0); place(7, 0); place(6, 0); place(8, 1);
    check_eq("draw_flags", {29'b0, a_w1, a_w2, a_dr}, 32'b001);
    check_eq("draw_mc", {27'b0, a_mc}, 32'd9);
    check_eq("draw_s1", {28'b0, a_s1}, 32'd1);
    check_eq("draw_s2", {28'b0, a_s2}, 32'd0);

    do_reset();
    check_idle(4'd0, 4'd0);

    // Occupied cell, then C and R in the same cycle.
    place(8, 0);
    press(BC);
    check_eq("occ_player", {31'b0, a_pl}, 32'd1);
    check_eq("occ_p2", {7'b0, a_p2}, 32'd0);
    goto(7);
    m_p2[7] = 1'b1;
    sb.push_back('{m_p1, m_p2});
    press(BC | BR);
    m_pl = 1'b0;
    check_eq("cr_player", {31'b0, a_pl}, 32'd0);
    check_eq("cr_cursor", {27'b0, a_i}, 32'd7);

    do_reset();
    press(BR);
`ifdef TTT_CURSOR_WRAP_EN
    check_eq("edge_r", {27'b0, a_i}, 32'd6);
`else
    check_eq("edge_r", {27'b0, a_i}, 32'd8);
`endif
    press(BD);
`ifdef TTT_CURSOR_WRAP_EN
    check_eq("edge_d", {27'b0, a_i}, 32'd0);
    m_row = 0; m_col = 0;
`else
    check_eq("edge_d", {27'b0, a_i}, 32'd8);
`endif

    // 4x4 board, K=3 diagonal.
    tn = 4;
    do_reset();
    check_idle(4'd0, 4'd0);
    place(5, 0); place(0, 0); place(10, 0); place(1, 0); place(15, 1);
    check_eq("n4_flags", {29'b0, a_w1, a_w2, a_dr}, 32'b100);
    check_eq("n4_score", {28'b0, a_s1}, 32'd1);
    check_eq("n4_mc", {27'b0, a_mc}, 32'd5);

    tick();
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tic_tac_toe_nxn.md
# tic_tac_toe_nxn

Parametrised N×N, K-in-a-row game engine. It is the next generation of the 3×3 `tic_tac_toe` board controller, and sits between the debounced push-button inputs and the display/convert logic. It provides:
- cursor navigation with edge-detected buttons,
- occupancy-checked move placement,
- sequential win/draw evaluation,
- per-player score counters that survive a game restart.

## Interface
- `N`, default 3: board side, legal 3..5.
- `K`, default 3: consecutive marks needed to win, legal 3..N.
- `CW`, default `$clog2(N*N)`: cursor index width.
- `Clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high. Clears everything, including scores.
- `restart` in 1: synchronous, active-high. Starts a new game and keeps the scores.
- `BtnL`, `BtnR`, `BtnU`, `BtnD`, `BtnC` in 1 each: debounced button levels. The block edge-detects them internally.
- `I` out CW: cursor cell index, computed as row*N+col, with row 0 at the top.
- `P1`, `P2` out N*N: occupancy bitmaps; bit i is cell i.
- `Player` out 1: side to move (0 = P1, 1 = P2).
- `PlayerMoved` out 1: one-cycle pulse when a mark is placed.
- `P1Won`, `P2Won`, `Draw` out 1 each: game-result flags, held until restart or reset.
- `MoveCount` out `$clog2(N*N+1)`: number of marks placed.
- `P1Score`, `P2Score` out 4 each: games won, saturating at 15.

## Operation
- Edge detect:
  - Each button has a previous-level register that loads the button level every cycle, including during reset and restart.
  - A press is the pattern level=1 with prev=0.
  - A button held through reset therefore does not act.
- Per-cycle priority: reset > restart > C > U > D > L > R. At most one action is taken per cycle; lower-priority edges in the same cycle are dropped.
- FSM states are PLAY, CHECK and DONE.
- PLAY:
  - U/D/L/R move the cursor by one row or column. At a board edge the cursor saturates (unchanged).
  - C on an empty cell (P1[I]|P2[I]==0): set the bit in the mover's bitmap, pulse PlayerMoved, increment MoveCount, go to CHECK.
  - C on an occupied cell: no effect, no pulse, state stays PLAY.
- CHECK, one cycle:
  - Evaluate the mover's bitmap for any K consecutive set bits along a row, column, diagonal or anti-diagonal, at every valid start position.
  - Win: set P<mover>Won, increment that score (saturating), go to DONE.
  - Otherwise, if MoveCount==N*N: set Draw, go to DONE.
  - Otherwise toggle Player and return to PLAY.
- DONE: all button edges are ignored. The bitmaps, the cursor and the flags hold.
- restart:
  - Clears P1, P2, the flags and MoveCount; sets Player=0, I=N*N-1 and state=PLAY.
  - Scores are kept.
  - It is legal in any state, including mid-CHECK; the pending result is discarded and no score is changed.
- reset: same as restart, and also clears both scores to 0.
- Reset values: `I`=N*N-1, `P1`=`P2`=0, `Player`=0, `PlayerMoved`=0, `P1Won`=`P2Won`=`Draw`=0, `MoveCount`=0, `P1Score`=`P2Score`=0, state PLAY.

## Timing
- A button rising level sampled at edge t is detected at edge t. Its action is registered, so outputs change after edge t.
- Cursor update: visible 1 cycle after the press is sampled.
- Placement: the bitmap bit and the PlayerMoved pulse are visible 1 cycle after the C press. PlayerMoved is high for exactly 1 cycle.
- Result: win/draw flags, or the toggled Player, are visible 2 cycles after the C press.
- New moves are accepted again 2 cycles after a placement. A C edge that lands in the CHECK cycle is dropped.
- Outputs are fully registered; there is no combinational path from buttons to outputs.

## Configuration
- `TTT_CURSOR_WRAP_EN` defined: cursor moves wrap within a row or column.
  - L at col 0 → col N-1; R at col N-1 → col 0.
  - U at row 0 → row N-1; D at row N-1 → row 0.
- Undefined (default): the cursor saturates at the edges.
- Nothing else differs between the two builds.

## Test plan
All cases use N=3, K=3 unless stated.
1. Reset with all buttons low → `I`=8, `P1`=`P2`=0, `Player`=0, all flags 0, `MoveCount`=0, scores 0.
2. Moves P1@8, P2@0, P1@5, P2@1, P1@2 → `P1`=9'h124, `P2`=9'h003.
   - `P1Won`=1 two cycles after the last C press.
   - `P1Score`=1, `MoveCount`=5.
   - A later U press leaves `I` unchanged.
3. C at 8, then C at 8 again → the second press gives no `PlayerMoved`, `P2`=0 and `Player`=1. Also, C and R pressed in the same cycle → the placement happens and the cursor does not move.
4. From `I`=8, press R, then D → `I` stays 8. With `TTT_CURSOR_WRAP_EN`: R → 6, then D → 0.
5. Draw sequence P1:0, P2:1, P1:2, P2:4, P1:3, P2:5, P1:7, P2:6, P1:8 → `Draw`=1, `MoveCount`=9, both Won flags 0, scores unchanged.
6. After scenario 2:
   - restart → board cleared, `I`=8, `Player`=0, `P1Score`=1.
   - Then reset → `P1Score`=0.
   - With N=4, K=3, moves P1 at cells 5, 10, 15 → `P1Won`.
